td4_decoder: RTL and testbench

- Instruction decoder for the TD4 4-bit CPU.
- Maps the 4-bit opcode (upper nibble of the instruction word) plus the carry flag to:
  - the ALU input-source select (SEL_A/SEL_B);
  - one-hot register load enables for A, B, OUT and PC.
- Sits between the program ROM and the register file / ALU mux.
- Outputs are registered: one clock of latency, asynchronous active-low reset.

---
 rtl/td4_decoder.sv | 85 ++++++++
 tb/tb_td4_decoder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/td4_decoder.sv
// TD4 instruction decoder: opcode + carry flag -> ALU source select and
// one-hot register load enables, registered with one cycle of latency.
module td4_decoder (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] OP_CODE,
    input  logic       C_FLAG,
    output logic [3:0] LOAD,
    output logic       SEL_A,
    output logic       SEL_B,
    output logic       ILLEGAL
);

    typedef enum logic [3:0] {
        OP_ADD_A_IM = 4'b0000,
        OP_MOV_A_B  = 4'b0001,
        OP_IN_A     = 4'b0010,
        OP_MOV_A_IM = 4'b0011,
        OP_MOV_B_A  = 4'b0100,
        OP_ADD_B_IM = 4'b0101,
        OP_IN_B     = 4'b0110,
        OP_MOV_B_IM = 4'b0111,
        OP_OUT_B    = 4'b1001,
        OP_OUT_IM   = 4'b1011,
        OP_JNC_IM   = 4'b1110,
        OP_JMP_IM   = 4'b1111
    } opcode_t;

    localparam logic [3:0] LD_A   = 4'b0001;
    localparam logic [3:0] LD_B   = 4'b0010;
    localparam logic [3:0] LD_OUT = 4'b0100;
    localparam logic [3:0] LD_PC  = 4'b1000;

    logic [3:0] w_load;
    logic [1:0] w_sel;
    logic       w_illegal;

    // C_FLAG is only referenced inside the JNC arm so an unknown carry
    // cannot leak into the decode of any other opcode.
    always_comb begin
        w_load    = '0;
        w_sel     = 2'b00;
        w_illegal = 1'b0;
        case (OP_CODE)
            OP_ADD_A_IM: begin w_sel = 2'b00; w_load = LD_A;   end
            OP_MOV_A_B:  begin w_sel = 2'b01; w_load = LD_A;   end
            OP_IN_A:     begin w_sel = 2'b10; w_load = LD_A;   end
            OP_MOV_A_IM: begin w_sel = 2'b11; w_load = LD_A;   end
            OP_MOV_B_A:  begin w_sel = 2'b00; w_load = LD_B;   end
            OP_ADD_B_IM: begin w_sel = 2'b01; w_load = LD_B;   end
            OP_IN_B:     begin w_sel = 2'b10; w_load = LD_B;   end
            OP_MOV_B_IM: begin w_sel = 2'b11; w_load = LD_B;   end
            OP_OUT_B:    begin w_sel = 2'b01; w_load = LD_OUT; end
            OP_OUT_IM:   begin w_sel = 2'b11; w_load = LD_OUT; end
            OP_JMP_IM:   begin w_sel = 2'b11; w_load = LD_PC;  end
            OP_JNC_IM: begin
                w_sel  = 2'b11;
                w_load = (C_FLAG == 1'b0) ? LD_PC : '0;
            end
            default:     w_illegal = 1'b1;
        endcase
    end

    logic [3:0] r_load;
    logic [1:0] r_sel;
    logic       r_illegal;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_load    <= '0;
            r_sel     <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_load    <= w_load;
            r_sel     <= w_sel;
            r_illegal <= w_illegal;
        end
    end

    assign LOAD    = r_load;
    assign SEL_A   = r_sel[0];
    assign SEL_B   = r_sel[1];
    assign ILLEGAL = r_illegal;

endmodule

// File: tb/tb_td4_decoder.sv
// Directed and random stimulus for td4_decoder, checked against a
// table-driven reference model of the TD4 instruction set.
module tb_td4_decoder;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] OP_CODE;
    logic       C_FLAG;
    logic [3:0] LOAD;
    logic       SEL_A;
    logic       SEL_B;
    logic       ILLEGAL;

    int unsigned errors = 0;
    int unsigned checks = 0;

    td4_decoder dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .OP_CODE(OP_CODE),
        .C_FLAG (C_FLAG),
        .LOAD   (LOAD),
        .SEL_A  (SEL_A),
        .SEL_B  (SEL_B),
        .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    // Instruction set table indexed by opcode: {SEL_B,SEL_A}, LOAD, illegal.
    logic [1:0] sel_t [16] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3,
                               2'd0, 2'd1, 2'd0, 2'd3, 2'd0, 2'd0, 2'd3, 2'd3};
    logic [3:0] ld_t  [16] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2,
                               4'd0, 4'd4, 4'd0, 4'd4, 4'd0, 4'd0, 4'd8, 4'd8};
    logic       ill_t [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    logic [6:0] w_obs;
    assign w_obs = {ILLEGAL, SEL_B, SEL_A, LOAD};

    function automatic logic [6:0] model(input logic [3:0] op, input logic c);
        logic [3:0] ld;
        ld = ld_t[op];
        if (op == 4'd14 && c) ld = 4'd0;
        return {ill_t[op], sel_t[op], ld};
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed={ILL,SEL,LOAD}=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply current inputs across one rising edge and compare the registered result.
    task automatic cycle(input string tag);
        logic [6:0] e;
        e = model(OP_CODE, C_FLAG);
        @(posedge CLK);
        #1;
        chk(tag, w_obs, e);
    endtask

    initial begin
        RST_N   = 1'b0;
        OP_CODE = 4'b0000;
        C_FLAG  = 1'b0;
        #1;
        chk("reset_initial", w_obs, 7'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            chk("reset_hold", w_obs, 7'd0);
        end
        RST_N = 1'b1;
        cycle("reset_release_add_a");
        chk("reset_release_const", w_obs, 7'b0_00_0001);

        // Conditional jump depends on carry; unconditional jump does not.
        OP_CODE = 4'b1110; C_FLAG = 1'b0;
        cycle("jnc_c0");
        chk("jnc_c0_const", w_obs, 7'b0_11_1000);
        C_FLAG = 1'b1;
        cycle("jnc_c1");
        chk("jnc_c1_const", w_obs, 7'b0_11_0000);
        OP_CODE = 4'b1111; C_FLAG = 1'b0;
        cycle("jmp_c0");
        C_FLAG = 1'b1;
        cycle("jmp_c1");
        chk("jmp_c1_const", w_obs, 7'b0_11_1000);

        C_FLAG = 1'b0;
        for (int op = 0; op < 16; op++) begin
            OP_CODE = 4'(op);
            cycle($sformatf("sweep_op%0d", op));
            if (op == 2)  chk("spot_in_a", w_obs, 7'b0_10_0001);
            if (op == 9)  chk("spot_out_b", w_obs, 7'b0_01_0100);
            if (op == 8 || op == 10 || op == 12 || op == 13)
                chk($sformatf("spot_undef%0d", op), w_obs, 7'b1_00_0000);
        end

        // Reset asserted between edges must clear outputs without a clock.
        OP_CODE = 4'b0111;
        cycle("pre_midrst_mov_b");
        #3;
        RST_N = 1'b0;
        #1;
        chk("midrun_async_reset", w_obs, 7'd0);
        @(posedge CLK);
        #1;
        chk("midrun_reset_held", w_obs, 7'd0);
        RST_N = 1'b1;
        cycle("midrun_release");

        for (int k = 0; k < 32; k++) begin
            logic [3:0] op;
            logic       c;
            logic       zero_ok;
            op = 4'(k >> 1);
            c  = k[0];
            OP_CODE = op; C_FLAG = c;
            cycle($sformatf("onehot_dec_%0d", k));
            zero_ok = ill_t[op] || (op == 4'd14 && c);
            chk($sformatf("onehot_pop_%0d", k), {6'd0, ($countones(LOAD) <= 1)}, 7'd1);
            chk($sformatf("onehot_zero_%0d", k), {6'd0, (LOAD == 4'd0)}, {6'd0, zero_ok});
        end

        for (int n = 0; n < 300; n++) begin
            OP_CODE = 4'($urandom);
            C_FLAG  = 1'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                #2;
                RST_N = 1'b0;
                #1;
                chk("rand_async_reset", w_obs, 7'd0);
                @(posedge CLK);
                #1;
                chk("rand_reset_held", w_obs, 7'd0);
                RST_N = 1'b1;
            end else begin
                cycle("rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
